acc_core_param: RTL

//  Parametrised successor of the team's 8-bit accumulator core: accumulator A plus NREG general registers.

---
 rtl/acc_core_param.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : acc_core_param
//  Purpose  : Parametrised accumulator core. It has accumulator A, NREG
//             general registers, a return stack (CALL/RET), absolute jumps,
//             run/single-step control, fault detection and a restart path.
//             Program RAM is written through a load port and then executed.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       clock, rising edge
//    rst_n      in   1       asynchronous active-low reset
//    prog_we    in   1       program RAM write strobe; the core holds while high
//    prog_addr  in   ADDR_W  program RAM write address
//    prog_data  in   DATA_W  program RAM write data
//    run        in   1       1 = free-run, 0 = single-step
//    step       in   1       one-cycle pulse; runs one instruction when run=0
//    restart    in   1       sync: PC=0, SP=0, flags=0, FSM to IDLE
//    acc_out    out  DATA_W  accumulator A
//    pc_out     out  ADDR_W  program counter
//    flags      out  3       {V,C,Z}
//    busy       out  1       FSM in FETCH/OPER/EXEC
//    halted     out  1       FSM in HALT
//    fault      out  1       FSM in FAULT
// ============================================================================
module acc_core_param #(
  parameter int DATA_W  = 8,   // >= 8; opcode is word[7:0]; ADDR_W <= DATA_W
  parameter int ADDR_W  = 5,
  parameter int NREG    = 4,   // 1..16
  parameter int STACK_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  input  logic              step,
  input  logic              restart,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        flags,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int MSB  = DATA_W - 1;
  localparam int SP_W = $clog2(STACK_D + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_OPER  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic [DATA_W-1:0] acc;
  logic [2:0]        flg;           // {V,C,Z}
  logic [7:0]        opcode;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] regs  [NREG];
  logic [ADDR_W-1:0] stack [STACK_D];
  logic [DATA_W-1:0] mem   [2**ADDR_W];

  // Program RAM: not reset; a restart in the same cycle blocks the write.
  always_ff @(posedge clk) begin
    if (prog_we && !restart) mem[prog_addr] <= prog_data;
  end

  logic [DATA_W-1:0] mem_word;
  assign mem_word = mem[pc];

  // 01-06 and 80-87 carry an operand word.
  function automatic logic two_word(input logic [7:0] op);
    return ((op[7:4] == 4'h0) && (op[3:0] >= 4'h1) && (op[3:0] <= 4'h6)) ||
           ((op[7:4] == 4'h8) && (op[3:0] <= 4'h7));
  endfunction

  // Register file read and range check for the r field.
  logic              reg_ok;
  logic [DATA_W-1:0] reg_val;
  assign reg_ok = (int'(opcode[3:0]) < NREG);
  always_comb begin
    reg_val = '0;
    for (int i = 0; i < NREG; i++)
      if (opcode[3:0] == 4'(i)) reg_val = regs[i];
  end

  // Top of the return stack (entry sp-1).
  logic [ADDR_W-1:0] stack_top;
  always_comb begin
    stack_top = '0;
    for (int i = 0; i < STACK_D; i++)
      if (sp == SP_W'(i + 1)) stack_top = stack[i];
  end

  // Shared adder: subtraction is a + ~b + 1, so carry-out means "no borrow".
  logic [DATA_W-1:0] add_a, add_b, add_bx, add_res;
  logic              add_sub, add_v;
  logic [DATA_W:0]   add_sum;
  logic [2:0]        arith_flg;

  always_comb begin
    add_a   = acc;
    add_b   = operand;
    add_sub = 1'b0;
    case (opcode[7:4])
      4'h0: add_sub = (opcode[3:0] == 4'h3);
      4'h2: add_b = reg_val;
      4'h3: begin add_b = reg_val; add_sub = 1'b1; end
      4'h6: begin add_a = reg_val; add_b = DATA_W'(1); end
      4'h7: begin add_a = reg_val; add_b = DATA_W'(1); add_sub = 1'b1; end
      default: ;
    endcase
  end

  assign add_bx    = add_b ^ {DATA_W{add_sub}};
  assign add_sum   = {1'b0, add_a} + {1'b0, add_bx} + {{DATA_W{1'b0}}, add_sub};
  assign add_res   = add_sum[MSB:0];
  assign add_v     = (add_a[MSB] == add_bx[MSB]) && (add_res[MSB] != add_a[MSB]);
  assign arith_flg = {add_v, add_sum[DATA_W], (add_res == '0)};

  // Execute-stage decode. Writes are committed only when x_err is clear,
  // so a faulting instruction leaves A, Rn and flags untouched.
  logic [DATA_W-1:0] x_acc, x_reg_val;
  logic [2:0]        x_flg;
  logic              x_acc_we, x_reg_we, x_jump, x_push, x_pop, x_halt, x_err;

  always_comb begin
    x_acc     = acc;
    x_acc_we  = 1'b0;
    x_reg_we  = 1'b0;
    x_reg_val = acc;
    x_flg     = flg;
    x_jump    = 1'b0;
    x_push    = 1'b0;
    x_pop     = 1'b0;
    x_halt    = 1'b0;
    x_err     = 1'b0;
    case (opcode[7:4])
      4'h0: begin
        case (opcode[3:0])
          4'h0: ;
          4'h1: begin x_acc = operand; x_acc_we = 1'b1; end
          4'h2, 4'h3: begin x_acc = add_res; x_acc_we = 1'b1; x_flg = arith_flg; end
          4'h4: begin x_acc = acc & operand; x_acc_we = 1'b1; x_flg[0] = (x_acc == '0); end
          4'h5: begin x_acc = acc | operand; x_acc_we = 1'b1; x_flg[0] = (x_acc == '0); end
          4'h6: begin x_acc = acc ^ operand; x_acc_we = 1'b1; x_flg[0] = (x_acc == '0); end
          4'h7: begin x_acc = ~acc;          x_acc_we = 1'b1; x_flg[0] = (x_acc == '0); end
          4'h8: begin
            x_acc = {acc[MSB-1:0], 1'b0}; x_acc_we = 1'b1;
            x_flg[1] = acc[MSB]; x_flg[0] = (x_acc == '0);
          end
          4'h9: begin
            x_acc = {1'b0, acc[MSB:1]}; x_acc_we = 1'b1;
            x_flg[1] = acc[0]; x_flg[0] = (x_acc == '0);
          end
          4'hA: x_halt = 1'b1;
          default: x_err = 1'b1;
        endcase
      end
      4'h2, 4'h3: begin
        if (!reg_ok) x_err = 1'b1;
        else begin x_acc = add_res; x_acc_we = 1'b1; x_flg = arith_flg; end
      end
      4'h4: begin
        if (!reg_ok) x_err = 1'b1;
        else x_reg_we = 1'b1;
      end
      4'h5: begin
        if (!reg_ok) x_err = 1'b1;
        else begin x_acc = reg_val; x_acc_we = 1'b1; end
      end
      4'h6, 4'h7: begin
        if (!reg_ok) x_err = 1'b1;
        else begin x_reg_val = add_res; x_reg_we = 1'b1; x_flg = arith_flg; end
      end
      4'h8: begin
        case (opcode[3:0])
          4'h0: x_jump = 1'b1;
          4'h1: x_jump = flg[0];
          4'h2: x_jump = ~flg[0];
          4'h3: x_jump = flg[1];
          4'h4: x_jump = ~flg[1];
          4'h5: x_jump = flg[2];
          4'h6: x_jump = ~flg[2];
          // pc already holds the return address when CALL executes.
          4'h7: begin
            if (sp == SP_W'(STACK_D)) x_err = 1'b1;
            else begin x_push = 1'b1; x_jump = 1'b1; end
          end
          4'h8: begin
            if (sp == '0) x_err = 1'b1;
            else x_pop = 1'b1;
          end
          default: x_err = 1'b1;
        endcase
      end
      default: x_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      sp      <= '0;
      acc     <= '0;
      flg     <= '0;
      opcode  <= '0;
      operand <= '0;
      for (int i = 0; i < NREG; i++)    regs[i]  <= '0;
      for (int i = 0; i < STACK_D; i++) stack[i] <= '0;
    end else if (restart) begin
      state <= S_IDLE;
      pc    <= '0;
      sp    <= '0;
      flg   <= '0;
    end else if (!prog_we) begin
      case (state)
        S_IDLE: if (run || step) state <= S_FETCH;
        S_FETCH: begin
          opcode <= mem_word[7:0];
          pc     <= pc + ADDR_W'(1);
          state  <= two_word(mem_word[7:0]) ? S_OPER : S_EXEC;
        end
        S_OPER: begin
          operand <= mem_word;
          pc      <= pc + ADDR_W'(1);
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (x_err) begin
            state <= S_FAULT;
          end else begin
            if (x_acc_we) acc <= x_acc;
            flg <= x_flg;
            for (int i = 0; i < NREG; i++)
              if (x_reg_we && opcode[3:0] == 4'(i)) regs[i] <= x_reg_val;
            for (int i = 0; i < STACK_D; i++)
              if (x_push && sp == SP_W'(i)) stack[i] <= pc;
            if (x_push) sp <= sp + SP_W'(1);
            if (x_pop) begin
              pc <= stack_top;
              sp <= sp - SP_W'(1);
            end else if (x_jump) begin
              pc <= operand[ADDR_W-1:0];
            end
            if (x_halt)   state <= S_HALT;
            else if (run) state <= S_FETCH;
            else          state <= S_IDLE;
          end
        end
        default: ;  // HALT and FAULT are left only by restart or reset
      endcase
    end
  end

  assign acc_out = acc;
  assign pc_out  = pc;
  assign flags   = flg;
  assign busy    = (state == S_FETCH) || (state == S_OPER) || (state == S_EXEC);
  assign halted  = (state == S_HALT);
  assign fault   = (state == S_FAULT);

endmodule
`default_nettype wire
